lfsr_rng_arbiter: RTL and testbench

- Shares one 16-bit XNOR-feedback Fibonacci LFSR among NUM_REQ requesters.
- Arbitration is round-robin. The granted requester receives one OUT_W-bit random word over a valid/ready handshake.
- The block also handles seed loading and all-ones lock-up protection.
- It sits between the shift-register datapath and the consumer blocks (test-pattern generators, scramblers) that need pseudo-random words.

---
 rtl/lfsr_rng_arbiter.sv | 148 ++++++++++++++
 tb/tb_lfsr_rng_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbiter sharing one 16-bit XNOR Fibonacci LFSR among NUM_REQ requesters.
// Each grant steps the LFSR OUT_W times and hands the low OUT_W bits over valid/ready.
module lfsr_rng_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int OUT_W   = 8,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rnd_valid,
    output logic [OUT_W-1:0]   rnd_data,
    output logic [ID_W-1:0]    rnd_id,
    input  logic               rnd_ready,
    input  logic               seed_load,
    input  logic [15:0]        seed_val,
    output logic               busy,
    output logic               lockup
);

    localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        DELIVER
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d, lfsr_step;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               valid_q, valid_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic               lockup_q, lockup_d;

    logic [2*NUM_REQ-1:0] req_rot;
    logic                 pick_found;
    int                   pick_pos;
    logic [ID_W-1:0]      pick_idx;

    assign lfsr_step = {lfsr_q[14:0], ~(lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10])};

    // Rotate the request vector so bit 0 is the requester just after rr_ptr,
    // then the first set bit is the round-robin winner.
    assign req_rot = {req, req} >> (int'(rr_ptr_q) + 1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        pick_found = 1'b0;
        pick_pos   = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!pick_found && req_rot[j]) begin
                pick_found = 1'b1;
                pick_pos   = int'(rr_ptr_q) + 1 + j;
            end
        end
        if (pick_pos >= NUM_REQ) begin
            pick_pos = pick_pos - NUM_REQ;
        end
        pick_idx = ID_W'(pick_pos);
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        valid_d  = valid_q;
        data_d   = data_q;
        lockup_d = 1'b0;

        case (state_q)
            IDLE: begin
                // A seed load wins the cycle; arbitration waits until the next one.
                if (seed_load) begin
                    if (seed_val == 16'hFFFF) begin
                        lfsr_d   = 16'h0000;
                        lockup_d = 1'b1;
                    end else begin
                        lfsr_d = seed_val;
                    end
                end else if (pick_found) begin
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    id_d    = pick_idx;
                    cnt_d   = '0;
                    state_d = GEN;
                end
            end
            GEN: begin
                lfsr_d = lfsr_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(OUT_W - 1)) begin
                    data_d  = lfsr_step[OUT_W-1:0];
                    valid_d = 1'b1;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                if (rnd_ready) begin
                    rr_ptr_d = id_q;
                    gnt_d    = '0;
                    valid_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            state_q  <= IDLE;
            lfsr_q   <= 16'h0000;
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
            id_q     <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            lockup_q <= lockup_d;
        end
    end

    assign gnt       = gnt_q;
    assign rnd_valid = valid_q;
    assign rnd_data  = data_q;
    assign rnd_id    = id_q;
    assign busy      = (state_q != IDLE);
    assign lockup    = lockup_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Self-checking bench for lfsr_rng_arbiter: directed scenarios plus randomized services,
// compared against a transaction-level model of the LFSR and round-robin pointer.
module tb_lfsr_rng_arbiter;

    localparam int NUM_REQ = 4;
    localparam int OUT_W   = 8;
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               rnd_valid;
    logic [OUT_W-1:0]   rnd_data;
    logic [ID_W-1:0]    rnd_id;
    logic               rnd_ready;
    logic               seed_load;
    logic [15:0]        seed_val;
    logic               busy;
    logic               lockup;

    int checks = 0;
    int errors = 0;

    // Model state: the shared LFSR value and the last-served requester.
    logic [15:0] m_lfsr;
    int          m_rr;

    logic [OUT_W-1:0] last_data;
    int               last_id;

    lfsr_rng_arbiter #(.NUM_REQ(NUM_REQ), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .rnd_id    (rnd_id),
        .rnd_ready (rnd_ready),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .busy      (busy),
        .lockup    (lockup)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ~(s[15] ^ s[13] ^ s[12] ^ s[10])};
    endfunction

    // Next requester after m_rr (wrapping) whose request bit is set.
    function automatic int model_pick(input logic [NUM_REQ-1:0] r);
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (r[(m_rr + i) % NUM_REQ]) return (m_rr + i) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_lfsr = 16'h0000;
        m_rr   = NUM_REQ - 1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},    32'(gnt),       32'h0);
        check({tag, "_valid"},  32'(rnd_valid), 32'h0);
        check({tag, "_data"},   32'(rnd_data),  32'h0);
        check({tag, "_id"},     32'(rnd_id),    32'h0);
        check({tag, "_busy"},   32'(busy),      32'h0);
        check({tag, "_lockup"}, 32'(lockup),    32'h0);
    endtask

    task automatic apply_reset(input string tag);
        rst       = 1'b1;
        req       = '0;
        rnd_ready = 1'b0;
        seed_load = 1'b0;
        @(posedge clk); #1;
        check_all_zero(tag);
        rst = 1'b0;
        model_reset();
    endtask

    // One complete service: grant, OUT_W generation cycles, delivery with
    // wait_cyc stall cycles, then acceptance. Optional noise on other inputs.
    task automatic service(input logic [NUM_REQ-1:0] r, input int wait_cyc,
                           input bit noise, input bit gen_seed);
        int                 pick;
        logic [NUM_REQ-1:0] exp_gnt;
        logic [OUT_W-1:0]   exp_word;
        pick    = model_pick(r);
        exp_gnt = onehot(pick);
        req     = r;
        @(posedge clk); #1;
        check("grant", 32'(gnt), 32'(exp_gnt));
        check("grant_busy", 32'(busy), 32'h1);
        check("grant_valid", 32'(rnd_valid), 32'h0);
        check("grant_lockup", 32'(lockup), 32'h0);
        if (noise) req = NUM_REQ'($urandom);
        for (int k = 0; k < OUT_W; k++) begin
            if (gen_seed && k == 0) begin
                seed_load = 1'b1;
                seed_val  = $urandom_range(0, 1) ? 16'hFFFF : 16'h0001;
            end
            if (noise) rnd_ready = 1'($urandom);
            @(posedge clk); #1;
            seed_load = 1'b0;
            m_lfsr    = lfsr_next(m_lfsr);
            check("gen_lockup", 32'(lockup), 32'h0);
            check("gen_gnt", 32'(gnt), 32'(exp_gnt));
            if (k < OUT_W - 1) check("gen_valid", 32'(rnd_valid), 32'h0);
        end
        exp_word  = m_lfsr[OUT_W-1:0];
        rnd_ready = 1'b0;
        check("dlv_valid", 32'(rnd_valid), 32'h1);
        check("dlv_data", 32'(rnd_data), 32'(exp_word));
        check("dlv_id", 32'(rnd_id), 32'(pick));
        last_data = rnd_data;
        last_id   = int'(rnd_id);
        for (int w = 0; w < wait_cyc; w++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(rnd_valid), 32'h1);
            check("stall_data", 32'(rnd_data), 32'(exp_word));
            check("stall_id", 32'(rnd_id), 32'(pick));
            check("stall_gnt", 32'(gnt), 32'(exp_gnt));
        end
        rnd_ready = 1'b1;
        @(posedge clk); #1;
        rnd_ready = 1'b0;
        check("accept_valid", 32'(rnd_valid), 32'h0);
        check("accept_gnt", 32'(gnt), 32'h0);
        check("accept_busy", 32'(busy), 32'h0);
        m_rr = pick;
    endtask

    task automatic seed_idle(input logic [15:0] val, input logic [NUM_REQ-1:0] r);
        seed_load = 1'b1;
        seed_val  = val;
        req       = r;
        @(posedge clk); #1;
        seed_load = 1'b0;
        check("seed_lockup", 32'(lockup), (val == 16'hFFFF) ? 32'h1 : 32'h0);
        check("seed_gnt", 32'(gnt), 32'h0);
        check("seed_busy", 32'(busy), 32'h0);
        m_lfsr = (val == 16'hFFFF) ? 16'h0000 : val;
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        rnd_ready = 1'b0;
        seed_load = 1'b0;
        seed_val  = '0;
        model_reset();
        @(posedge clk);
        apply_reset("reset");

        // First two words from the reset LFSR value.
        service(4'b0001, 0, 1'b0, 1'b0);
        check("first_word", 32'(last_data), 32'hFF);
        service(4'b0001, 0, 1'b0, 1'b0);
        check("second_word", 32'(last_data), 32'hE4);

        // Rotation with all requesters held.
        apply_reset("reset_rot");
        for (int i = 0; i < 5; i++) begin
            service(4'b1111, 0, 1'b0, 1'b0);
            check("rot_id", 32'(last_id), 32'(i % NUM_REQ));
        end

        // Consumer stalls for five cycles.
        service(4'b0110, 5, 1'b0, 1'b0);

        // All-ones seed rejected, then a seed attempt during GEN is ignored.
        req = '0;
        seed_idle(16'hFFFF, '0);
        @(posedge clk); #1;
        check("lockup_pulse_end", 32'(lockup), 32'h0);
        service(4'b0010, 0, 1'b0, 1'b1);
        check("post_lockup_word", 32'(last_data), 32'hFF);

        // Seed and request in the same IDLE cycle.
        seed_idle(16'hACE1, 4'b0100);
        service(4'b0100, 1, 1'b0, 1'b0);

        // Reset in the middle of GEN.
        req = 4'b1000;
        @(posedge clk); #1;
        check("midgen_grant", 32'(busy), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        apply_reset("rst_gen");

        // Reset in the middle of DELIVER.
        req = 4'b0100;
        repeat (OUT_W + 1) @(posedge clk);
        #1;
        check("middlv_valid", 32'(rnd_valid), 32'h1);
        apply_reset("rst_dlv");
        service(4'b1111, 0, 1'b0, 1'b0);
        check("after_rst_id", 32'(last_id), 32'h0);
        check("after_rst_word", 32'(last_data), 32'hFF);

        // Randomized services.
        for (int n = 0; n < 25; n++) begin
            logic [NUM_REQ-1:0] r;
            r = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            if ($urandom_range(0, 3) == 0) begin
                seed_idle(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom), r);
            end
            service(r, $urandom_range(0, 3), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
